hockey_param: RTL and testbench



---
 rtl/hockey_param.sv | 318 +++++++++++++++++++++++++++++++
 tb/tb_hockey_param.sv | 379 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hockey_param.sv
// hockey_param: parametrised two-player air-hockey game controller.
// Drives puck position, scores, state code, serving side and winner flag.
// Optional feature macro HOCKEY_SPEEDUP_EN: each successful return shortens
// the puck step period by one cycle (floor 1), reloaded on every goal.
module hockey_param #(
    parameter int X_MAX      = 4,
    parameter int Y_MAX      = 4,
    parameter int COORD_W    = 3,
    parameter int WAIT_TICKS = 3,
    parameter int WIN_SCORE  = 3,
    parameter int SCORE_W    = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               BTN_A,
    input  logic               BTN_B,
    input  logic [1:0]         DIR_A,
    input  logic [1:0]         DIR_B,
    input  logic [COORD_W-1:0] Y_in_A,
    input  logic [COORD_W-1:0] Y_in_B,
    output logic [COORD_W-1:0] X_COORD,
    output logic [COORD_W-1:0] Y_COORD,
    output logic [SCORE_W-1:0] SCORE_A,
    output logic [SCORE_W-1:0] SCORE_B,
    output logic [3:0]         STATE_OUT,
    output logic               TURN,
    output logic [1:0]         WINNER
);

    localparam int TIMER_W = $clog2(WAIT_TICKS + 1);

    localparam logic [COORD_W-1:0] X_MAX_C   = COORD_W'(X_MAX);
    localparam logic [COORD_W-1:0] X_RET_B_C = COORD_W'(X_MAX - 1);
    localparam logic [COORD_W-1:0] X_RET_A_C = COORD_W'(1);
    localparam logic [COORD_W-1:0] Y_MAX_C   = COORD_W'(Y_MAX);
    localparam logic [SCORE_W-1:0] WIN_C     = SCORE_W'(WIN_SCORE);
    localparam logic [TIMER_W-1:0] WAIT_LAST = TIMER_W'(WAIT_TICKS - 1);

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_DISP   = 4'd1,
        S_HIT_A  = 4'd2,
        S_HIT_B  = 4'd3,
        S_SEND_A = 4'd4,
        S_SEND_B = 4'd5,
        S_RESP_A = 4'd6,
        S_RESP_B = 4'd7,
        S_GOAL_A = 4'd8,
        S_GOAL_B = 4'd9,
        S_END    = 4'd10
    } state_e;

    typedef enum logic [1:0] {
        DIR_STRAIGHT = 2'b00,
        DIR_UP       = 2'b01,
        DIR_DOWN     = 2'b10
    } dir_e;

    typedef struct packed {
        dir_e               dir;
        logic [COORD_W-1:0] y;
    } move_t;

    // The unused 11 code is folded onto straight so the direction register
    // only ever holds one of the three legal values.
    function automatic dir_e cleanDir(input logic [1:0] raw);
        dir_e d;
        case (raw)
            2'b01:   d = DIR_UP;
            2'b10:   d = DIR_DOWN;
            default: d = DIR_STRAIGHT;
        endcase
        return d;
    endfunction

    // One vertical puck step, reflecting off the top and bottom walls.
    function automatic move_t bounce(input logic [COORD_W-1:0] y, input dir_e d);
        move_t m;
        m.dir = d;
        m.y   = y;
        case (d)
            DIR_UP: begin
                if (y >= Y_MAX_C) begin
                    m.dir = DIR_DOWN;
                    m.y   = y - 1'b1;
                end else begin
                    m.y   = y + 1'b1;
                end
            end
            DIR_DOWN: begin
                if (y == '0) begin
                    m.dir = DIR_UP;
                    m.y   = y + 1'b1;
                end else begin
                    m.y   = y - 1'b1;
                end
            end
            default: ;
        endcase
        return m;
    endfunction

    state_e             state_q,  state_d;
    logic [TIMER_W-1:0] timer_q,  timer_d;
    logic [COORD_W-1:0] xPos_q,   xPos_d;
    logic [COORD_W-1:0] yPos_q,   yPos_d;
    dir_e               dir_q,    dir_d;
    logic [SCORE_W-1:0] scoreA_q, scoreA_d;
    logic [SCORE_W-1:0] scoreB_q, scoreB_d;
    logic               turn_q,   turn_d;
    logic [1:0]         winner_q, winner_d;

    logic [TIMER_W-1:0] stepLast;
    move_t              stepMove;
    move_t              returnMoveA;
    move_t              returnMoveB;
    logic               hitA;
    logic               hitB;

`ifdef HOCKEY_SPEEDUP_EN
    logic [TIMER_W-1:0] period_q, period_d;

    assign stepLast = period_q - 1'b1;
`else
    assign stepLast = WAIT_LAST;
`endif

    assign stepMove    = bounce(yPos_q, dir_q);
    assign returnMoveA = bounce(yPos_q, cleanDir(DIR_A));
    assign returnMoveB = bounce(yPos_q, cleanDir(DIR_B));
    assign hitA        = BTN_A && (Y_in_A == yPos_q);
    assign hitB        = BTN_B && (Y_in_B == yPos_q);

    // Next-state logic: the timer defaults to zero so any state change clears it.
    always_comb begin
        state_d  = state_q;
        timer_d  = '0;
        xPos_d   = xPos_q;
        yPos_d   = yPos_q;
        dir_d    = dir_q;
        scoreA_d = scoreA_q;
        scoreB_d = scoreB_q;
        turn_d   = turn_q;
        winner_d = winner_q;
`ifdef HOCKEY_SPEEDUP_EN
        period_d = period_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (BTN_A) begin
                    turn_d  = 1'b0;
                    state_d = S_DISP;
                end else if (BTN_B) begin
                    turn_d  = 1'b1;
                    state_d = S_DISP;
                end
            end
            S_DISP: begin
                if (timer_q == WAIT_LAST) begin
                    state_d = turn_q ? S_HIT_B : S_HIT_A;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            S_HIT_A: begin
                if (BTN_A && (Y_in_A <= Y_MAX_C)) begin
                    xPos_d  = '0;
                    yPos_d  = Y_in_A;
                    dir_d   = cleanDir(DIR_A);
                    state_d = S_SEND_B;
                end
            end
            S_HIT_B: begin
                if (BTN_B && (Y_in_B <= Y_MAX_C)) begin
                    xPos_d  = X_MAX_C;
                    yPos_d  = Y_in_B;
                    dir_d   = cleanDir(DIR_B);
                    state_d = S_SEND_A;
                end
            end
            S_SEND_B: begin
                if (timer_q == stepLast) begin
                    xPos_d = xPos_q + 1'b1;
                    yPos_d = stepMove.y;
                    dir_d  = stepMove.dir;
                    if (xPos_d == X_MAX_C) begin
                        state_d = S_RESP_B;
                    end
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            S_SEND_A: begin
                if (timer_q == stepLast) begin
                    xPos_d = xPos_q - 1'b1;
                    yPos_d = stepMove.y;
                    dir_d  = stepMove.dir;
                    if (xPos_d == '0) begin
                        state_d = S_RESP_A;
                    end
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            S_RESP_B: begin
                if (hitB) begin
                    xPos_d  = X_RET_B_C;
                    yPos_d  = returnMoveB.y;
                    dir_d   = returnMoveB.dir;
                    state_d = S_SEND_A;
`ifdef HOCKEY_SPEEDUP_EN
                    if (period_q != TIMER_W'(1)) period_d = period_q - 1'b1;
`endif
                end else if (timer_q == WAIT_LAST) begin
                    if (scoreA_q != WIN_C) scoreA_d = scoreA_q + 1'b1;
                    state_d = S_GOAL_A;
`ifdef HOCKEY_SPEEDUP_EN
                    period_d = TIMER_W'(WAIT_TICKS);
`endif
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            S_RESP_A: begin
                if (hitA) begin
                    xPos_d  = X_RET_A_C;
                    yPos_d  = returnMoveA.y;
                    dir_d   = returnMoveA.dir;
                    state_d = S_SEND_B;
`ifdef HOCKEY_SPEEDUP_EN
                    if (period_q != TIMER_W'(1)) period_d = period_q - 1'b1;
`endif
                end else if (timer_q == WAIT_LAST) begin
                    if (scoreB_q != WIN_C) scoreB_d = scoreB_q + 1'b1;
                    state_d = S_GOAL_B;
`ifdef HOCKEY_SPEEDUP_EN
                    period_d = TIMER_W'(WAIT_TICKS);
`endif
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            S_GOAL_A: begin
                if (timer_q == WAIT_LAST) begin
                    if (scoreA_q == WIN_C) begin
                        winner_d = 2'b01;
                        turn_d   = 1'b0;
                        state_d  = S_END;
                    end else begin
                        state_d  = S_HIT_B;
                    end
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            S_GOAL_B: begin
                if (timer_q == WAIT_LAST) begin
                    if (scoreB_q == WIN_C) begin
                        winner_d = 2'b10;
                        turn_d   = 1'b1;
                        state_d  = S_END;
                    end else begin
                        state_d  = S_HIT_A;
                    end
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            S_END: ;
            default: state_d = S_IDLE;
        endcase
    end

    // Game state registers, cleared immediately by the asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            timer_q  <= '0;
            xPos_q   <= '0;
            yPos_q   <= '0;
            dir_q    <= DIR_STRAIGHT;
            scoreA_q <= '0;
            scoreB_q <= '0;
            turn_q   <= 1'b0;
            winner_q <= 2'b00;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            xPos_q   <= xPos_d;
            yPos_q   <= yPos_d;
            dir_q    <= dir_d;
            scoreA_q <= scoreA_d;
            scoreB_q <= scoreB_d;
            turn_q   <= turn_d;
            winner_q <= winner_d;
        end
    end

`ifdef HOCKEY_SPEEDUP_EN
    // Effective puck step period, shrinking with each return during a rally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            period_q <= TIMER_W'(WAIT_TICKS);
        end else begin
            period_q <= period_d;
        end
    end
`endif

    assign X_COORD   = xPos_q;
    assign Y_COORD   = yPos_q;
    assign SCORE_A   = scoreA_q;
    assign SCORE_B   = scoreB_q;
    assign STATE_OUT = state_q;
    assign TURN      = turn_q;
    assign WINNER    = winner_q;

endmodule

// File: tb/tb_hockey_param.sv
// tb_hockey_param: self-checking bench for hockey_param with default parameters.
// Honours HOCKEY_SPEEDUP_EN so it can be compiled alongside either build.
module tb_hockey_param;

    localparam int X_MAX      = 4;
    localparam int Y_MAX      = 4;
    localparam int COORD_W    = 3;
    localparam int WAIT_TICKS = 3;
    localparam int WIN_SCORE  = 3;
    localparam int SCORE_W    = 2;

`ifdef HOCKEY_SPEEDUP_EN
    localparam bit SPEEDUP = 1'b1;
    localparam int P1      = 2;
`else
    localparam bit SPEEDUP = 1'b0;
    localparam int P1      = 3;
`endif

    localparam int ST_IDLE = 0, ST_DISP = 1, ST_HIT_A = 2, ST_HIT_B = 3;
    localparam int ST_SEND_A = 4, ST_SEND_B = 5, ST_RESP_A = 6, ST_RESP_B = 7;
    localparam int ST_GOAL_A = 8, ST_GOAL_B = 9, ST_END = 10;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               btnA = 1'b0;
    logic               btnB = 1'b0;
    logic [1:0]         dirA = 2'b00;
    logic [1:0]         dirB = 2'b00;
    logic [COORD_W-1:0] yInA = '0;
    logic [COORD_W-1:0] yInB = '0;
    logic [COORD_W-1:0] xCoord;
    logic [COORD_W-1:0] yCoord;
    logic [SCORE_W-1:0] scoreA;
    logic [SCORE_W-1:0] scoreB;
    logic [3:0]         stateOut;
    logic               turn;
    logic [1:0]         winner;

    int checks   = 0;
    int failures = 0;

    hockey_param #(
        .X_MAX(X_MAX), .Y_MAX(Y_MAX), .COORD_W(COORD_W),
        .WAIT_TICKS(WAIT_TICKS), .WIN_SCORE(WIN_SCORE), .SCORE_W(SCORE_W)
    ) dut (
        .clk(clk), .rst(rst),
        .BTN_A(btnA), .BTN_B(btnB), .DIR_A(dirA), .DIR_B(dirB),
        .Y_in_A(yInA), .Y_in_B(yInB),
        .X_COORD(xCoord), .Y_COORD(yCoord),
        .SCORE_A(scoreA), .SCORE_B(scoreB),
        .STATE_OUT(stateOut), .TURN(turn), .WINNER(winner)
    );

    always #5 clk = ~clk;

    // Directed vectors: inputs held for n cycles (buttons pulse once), then expected outputs.
    typedef struct {
        int ba; int bb; int da; int db; int ya; int yb; int n;
        int eSt; int eX; int eY; int eSA; int eSB; int eTurn; int eWin;
    } vec_t;
    vec_t vecs[$];

    function automatic void addVec(int ba, int bb, int da, int db, int ya, int yb, int n,
                                   int eSt, int eX, int eY, int eSA, int eSB, int eTurn, int eWin);
        vec_t v;
        v = '{ba, bb, da, db, ya, yb, n, eSt, eX, eY, eSA, eSB, eTurn, eWin};
        vecs.push_back(v);
    endfunction

    // Behavioural game model: puck velocity, dwell countdowns and scores as plain integers.
    int mState, mX, mY, mVy, mSA, mSB, mTurn, mWin, mLeft, mPeriod;

    function automatic int dirToVel(input int d);
        if (d == 1) return 1;
        if (d == 2) return -1;
        return 0;
    endfunction

    task automatic modelReset();
        mState = ST_IDLE; mX = 0; mY = 0; mVy = 0; mSA = 0; mSB = 0;
        mTurn = 0; mWin = 0; mLeft = 0; mPeriod = WAIT_TICKS;
    endtask

    task automatic modelMoveY();
        int ny;
        ny = mY + mVy;
        if (ny > Y_MAX || ny < 0) begin
            mVy = -mVy;
            ny  = mY + mVy;
        end
        mY = ny;
    endtask

    task automatic modelClock(input int ba, input int bb, input int da, input int db,
                              input int ya, input int yb);
        case (mState)
            ST_IDLE: begin
                if (ba != 0) begin mTurn = 0; mState = ST_DISP; mLeft = WAIT_TICKS; end
                else if (bb != 0) begin mTurn = 1; mState = ST_DISP; mLeft = WAIT_TICKS; end
            end
            ST_DISP: begin
                mLeft--;
                if (mLeft == 0) mState = (mTurn == 1) ? ST_HIT_B : ST_HIT_A;
            end
            ST_HIT_A: if (ba != 0 && ya <= Y_MAX) begin
                mX = 0; mY = ya; mVy = dirToVel(da); mState = ST_SEND_B; mLeft = mPeriod;
            end
            ST_HIT_B: if (bb != 0 && yb <= Y_MAX) begin
                mX = X_MAX; mY = yb; mVy = dirToVel(db); mState = ST_SEND_A; mLeft = mPeriod;
            end
            ST_SEND_B: begin
                mLeft--;
                if (mLeft == 0) begin
                    mX++; modelMoveY(); mLeft = mPeriod;
                    if (mX == X_MAX) begin mState = ST_RESP_B; mLeft = WAIT_TICKS; end
                end
            end
            ST_SEND_A: begin
                mLeft--;
                if (mLeft == 0) begin
                    mX--; modelMoveY(); mLeft = mPeriod;
                    if (mX == 0) begin mState = ST_RESP_A; mLeft = WAIT_TICKS; end
                end
            end
            ST_RESP_B: begin
                if (bb != 0 && yb == mY) begin
                    mX = X_MAX - 1; mVy = dirToVel(db); modelMoveY();
                    if (SPEEDUP && mPeriod > 1) mPeriod--;
                    mState = ST_SEND_A; mLeft = mPeriod;
                end else begin
                    mLeft--;
                    if (mLeft == 0) begin
                        if (mSA < WIN_SCORE) mSA++;
                        mPeriod = WAIT_TICKS; mState = ST_GOAL_A; mLeft = WAIT_TICKS;
                    end
                end
            end
            ST_RESP_A: begin
                if (ba != 0 && ya == mY) begin
                    mX = 1; mVy = dirToVel(da); modelMoveY();
                    if (SPEEDUP && mPeriod > 1) mPeriod--;
                    mState = ST_SEND_B; mLeft = mPeriod;
                end else begin
                    mLeft--;
                    if (mLeft == 0) begin
                        if (mSB < WIN_SCORE) mSB++;
                        mPeriod = WAIT_TICKS; mState = ST_GOAL_B; mLeft = WAIT_TICKS;
                    end
                end
            end
            ST_GOAL_A: begin
                mLeft--;
                if (mLeft == 0) begin
                    if (mSA == WIN_SCORE) begin mWin = 1; mTurn = 0; mState = ST_END; end
                    else mState = ST_HIT_B;
                end
            end
            ST_GOAL_B: begin
                mLeft--;
                if (mLeft == 0) begin
                    if (mSB == WIN_SCORE) begin mWin = 2; mTurn = 1; mState = ST_END; end
                    else mState = ST_HIT_A;
                end
            end
            default: ;
        endcase
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input int ba, input int bb, input int da, input int db,
                                 input int ya, input int yb, input int n);
        btnA = (ba != 0); btnB = (bb != 0);
        dirA = 2'(da); dirB = 2'(db);
        yInA = COORD_W'(ya); yInB = COORD_W'(yb);
        for (int k = 0; k < n; k++) begin
            tick();
            btnA = 1'b0;
            btnB = 1'b0;
        end
    endtask

    task automatic checkOutput(input string tag, input int eSt, input int eX, input int eY,
                               input int eSA, input int eSB, input int eTurn, input int eWin);
        checks++;
        if (int'(stateOut) != eSt || int'(xCoord) != eX || int'(yCoord) != eY ||
            int'(scoreA) != eSA || int'(scoreB) != eSB || int'(turn) != eTurn ||
            int'(winner) != eWin) begin
            failures++;
            $display("[TB] FAIL %s: got st=%0d x=%0d y=%0d sa=%0d sb=%0d turn=%0d win=%0d, expected st=%0d x=%0d y=%0d sa=%0d sb=%0d turn=%0d win=%0d",
                     tag, stateOut, xCoord, yCoord, scoreA, scoreB, turn, winner,
                     eSt, eX, eY, eSA, eSB, eTurn, eWin);
        end
    endtask

    task automatic waitState(input string tag, input int code, input int budget);
        int k;
        k = 0;
        while (int'(stateOut) != code && k < budget) begin
            tick();
            k++;
        end
        checks++;
        if (int'(stateOut) != code) begin
            failures++;
            $display("[TB] FAIL %s: state=%0d after %0d cycles, expected %0d", tag, stateOut, k, code);
        end
    endtask

    task automatic measureStep(input string tag, input int expected);
        logic [COORD_W-1:0] x0;
        int n;
        x0 = xCoord;
        n  = 0;
        do begin
            tick();
            n++;
        end while (xCoord == x0 && n < 20);
        checks++;
        if (n != expected) begin
            failures++;
            $display("[TB] FAIL %s: step period %0d cycles, expected %0d", tag, n, expected);
        end
    endtask

    task automatic doReset();
        btnA = 1'b0; btnB = 1'b0; dirA = 2'b00; dirB = 2'b00; yInA = '0; yInB = '0;
        #2 rst = 1'b1;
        #2 rst = 1'b0;
        tick();
        modelReset();
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int ba, bb, da, db, ya, yb, guard;
        modelReset();
        tick();
        tick();
        #2 rst = 1'b0;
        tick();

        // Directed walk: serve, straight flight, return, misses, bounces at both walls.
        addVec(0, 0, 0, 0, 0, 0, 1,        ST_IDLE,   0, 0, 0, 0, 0, 0);
        addVec(1, 1, 0, 0, 0, 0, 1,        ST_DISP,   0, 0, 0, 0, 0, 0);
        addVec(0, 0, 0, 0, 0, 0, 2,        ST_DISP,   0, 0, 0, 0, 0, 0);
        addVec(0, 0, 0, 0, 0, 0, 1,        ST_HIT_A,  0, 0, 0, 0, 0, 0);
        addVec(1, 0, 0, 0, 5, 0, 1,        ST_HIT_A,  0, 0, 0, 0, 0, 0);
        addVec(1, 0, 0, 0, 2, 0, 1,        ST_SEND_B, 0, 2, 0, 0, 0, 0);
        addVec(0, 0, 0, 0, 0, 0, 2,        ST_SEND_B, 0, 2, 0, 0, 0, 0);
        addVec(0, 0, 0, 0, 0, 0, 1,        ST_SEND_B, 1, 2, 0, 0, 0, 0);
        addVec(0, 0, 0, 0, 0, 0, 3,        ST_SEND_B, 2, 2, 0, 0, 0, 0);
        addVec(0, 0, 0, 0, 0, 0, 6,        ST_RESP_B, 4, 2, 0, 0, 0, 0);
        addVec(0, 0, 0, 0, 0, 0, 1,        ST_RESP_B, 4, 2, 0, 0, 0, 0);
        addVec(0, 1, 0, 0, 0, 2, 1,        ST_SEND_A, 3, 2, 0, 0, 0, 0);
        addVec(0, 0, 0, 0, 0, 0, 3 * P1,   ST_RESP_A, 0, 2, 0, 0, 0, 0);
        addVec(1, 0, 0, 0, 1, 0, 1,        ST_RESP_A, 0, 2, 0, 0, 0, 0);
        addVec(1, 0, 0, 0, 3, 0, 1,        ST_RESP_A, 0, 2, 0, 0, 0, 0);
        addVec(1, 0, 0, 0, 0, 0, 1,        ST_GOAL_B, 0, 2, 0, 1, 0, 0);
        addVec(0, 0, 0, 0, 0, 0, 2,        ST_GOAL_B, 0, 2, 0, 1, 0, 0);
        addVec(0, 0, 0, 0, 0, 0, 1,        ST_HIT_A,  0, 2, 0, 1, 0, 0);
        addVec(1, 0, 1, 0, 3, 0, 1,        ST_SEND_B, 0, 3, 0, 1, 0, 0);
        addVec(0, 0, 0, 0, 0, 0, 3,        ST_SEND_B, 1, 4, 0, 1, 0, 0);
        addVec(0, 0, 0, 0, 0, 0, 3,        ST_SEND_B, 2, 3, 0, 1, 0, 0);
        addVec(0, 0, 0, 0, 0, 0, 3,        ST_SEND_B, 3, 2, 0, 1, 0, 0);
        addVec(0, 0, 0, 0, 0, 0, 3,        ST_RESP_B, 4, 1, 0, 1, 0, 0);
        addVec(0, 1, 0, 0, 0, 0, 1,        ST_RESP_B, 4, 1, 0, 1, 0, 0);
        addVec(0, 1, 0, 0, 0, 2, 1,        ST_RESP_B, 4, 1, 0, 1, 0, 0);
        addVec(0, 1, 0, 0, 0, 4, 1,        ST_GOAL_A, 4, 1, 1, 1, 0, 0);
        addVec(0, 0, 0, 0, 0, 0, 2,        ST_GOAL_A, 4, 1, 1, 1, 0, 0);
        addVec(0, 0, 0, 0, 0, 0, 1,        ST_HIT_B,  4, 1, 1, 1, 0, 0);
        addVec(0, 1, 0, 2, 0, 0, 1,        ST_SEND_A, 4, 0, 1, 1, 0, 0);
        addVec(0, 0, 0, 0, 0, 0, 3,        ST_SEND_A, 3, 1, 1, 1, 0, 0);
        addVec(0, 0, 0, 0, 0, 0, 3,        ST_SEND_A, 2, 2, 1, 1, 0, 0);
        addVec(0, 0, 0, 0, 0, 0, 3,        ST_SEND_A, 1, 3, 1, 1, 0, 0);
        addVec(0, 0, 0, 0, 0, 0, 3,        ST_RESP_A, 0, 4, 1, 1, 0, 0);
        addVec(0, 0, 0, 0, 0, 0, 3,        ST_GOAL_B, 0, 4, 1, 2, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].ba, vecs[i].bb, vecs[i].da, vecs[i].db,
                          vecs[i].ya, vecs[i].yb, vecs[i].n);
            checkOutput($sformatf("vec%0d", i), vecs[i].eSt, vecs[i].eX, vecs[i].eY,
                        vecs[i].eSA, vecs[i].eSB, vecs[i].eTurn, vecs[i].eWin);
        end

        // Asynchronous reset mid-flight: outputs clear without waiting for a clock edge.
        doReset();
        applyStimulus(1, 0, 0, 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 3);
        applyStimulus(1, 0, 1, 0, 1, 0, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 6);
        checkOutput("preReset", ST_SEND_B, 2, 3, 0, 0, 0, 0);
        #2 rst = 1'b1;
        #1;
        checkOutput("asyncReset", ST_IDLE, 0, 0, 0, 0, 0, 0);
        #1 rst = 1'b0;
        tick();
        modelReset();

        // A wins three goals in a row; B never returns, A always returns.
        guard = 0;
        while (int'(stateOut) != ST_END && guard < 600) begin
            btnA = 1'b0; btnB = 1'b0; dirA = 2'b00; dirB = 2'b00; yInA = '0; yInB = '0;
            case (int'(stateOut))
                ST_IDLE, ST_HIT_A, ST_RESP_A: btnA = 1'b1;
                ST_HIT_B:                     btnB = 1'b1;
                default: ;
            endcase
            tick();
            guard++;
        end
        btnA = 1'b0; btnB = 1'b0;
        checkOutput("aWins", ST_END, 4, 0, 3, 0, 0, 1);
        for (int k = 0; k < 12; k++) begin
            btnA = 1'($urandom); btnB = 1'($urandom);
            dirA = 2'($urandom); dirB = 2'($urandom);
            yInA = COORD_W'($urandom); yInB = COORD_W'($urandom);
            tick();
            checkOutput($sformatf("endHold%0d", k), ST_END, 4, 0, 3, 0, 0, 1);
        end

`ifdef HOCKEY_SPEEDUP_EN
        // Step period shrinks 3,2,1,1 over three returns and reloads after a goal.
        doReset();
        applyStimulus(1, 0, 0, 0, 0, 0, 1);
        waitState("spdHitA", ST_HIT_A, 10);
        applyStimulus(1, 0, 0, 0, 0, 0, 1);
        measureStep("spdLeg0", 3);
        waitState("spdRespB0", ST_RESP_B, 30);
        applyStimulus(0, 1, 0, 0, 0, 0, 1);
        measureStep("spdLeg1", 2);
        waitState("spdRespA1", ST_RESP_A, 30);
        applyStimulus(1, 0, 0, 0, 0, 0, 1);
        measureStep("spdLeg2", 1);
        waitState("spdRespB2", ST_RESP_B, 30);
        applyStimulus(0, 1, 0, 0, 0, 0, 1);
        measureStep("spdLeg3", 1);
        waitState("spdRespA3", ST_RESP_A, 30);
        waitState("spdGoalB", ST_GOAL_B, 10);
        waitState("spdHitA2", ST_HIT_A, 10);
        applyStimulus(1, 0, 0, 0, 0, 0, 1);
        measureStep("spdReload", 3);
`endif

        // Randomized play against the behavioural model, with occasional resets.
        doReset();
        for (int c = 0; c < 4000; c++) begin
            if ((mState == ST_END && ($urandom % 6) == 0) || ($urandom % 900) == 0) begin
                doReset();
            end
            ba = (($urandom % 4) == 0) ? 1 : 0;
            bb = (($urandom % 4) == 0) ? 1 : 0;
            da = int'($urandom % 4);
            db = int'($urandom % 4);
            ya = (($urandom % 2) == 0) ? mY : int'($urandom % 8);
            yb = (($urandom % 2) == 0) ? mY : int'($urandom % 8);
            btnA = (ba != 0); btnB = (bb != 0);
            dirA = 2'(da); dirB = 2'(db);
            yInA = COORD_W'(ya); yInB = COORD_W'(yb);
            @(posedge clk);
            modelClock(ba, bb, da, db, ya, yb);
            #1;
            checkOutput($sformatf("rand%0d", c), mState, mX, mY, mSA, mSB, mTurn, mWin);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
